// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and the {pc, instruction} entry type for the fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with synchronous reset and flush
// clk_i/rst_i: clock, sync active-high reset; flush_i: drop all entries
// push_i/data_i: write; pop_i/data_o: head read (combinational); count_o/full_o/empty_o: occupancy
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    output fetch_entry_t               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q, count_d;
    assign count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
        end
    end
    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i && !flush_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
endmodule

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: fetch PC owner feeding a decoupled {pc, instruction} queue to decode
// clk/reset: clock, sync active-high reset; initial_address: PC loaded on reset
// redirect_valid/redirect_address: flush and restart fetch at a new (word-aligned) PC
// mem_address/mem_instruction: external combinational instruction memory port
// out_valid/out_ready/out_pc/out_instruction: head of the queue towards decode
module instruction_fetch_buffer import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] initial_address,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_address,
    output logic [XLEN-1:0] mem_address,
    input  logic [XLEN-1:0] mem_instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instruction
);
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, push, pop;
    fetch_entry_t wr_entry, head;
    assign pop  = out_valid && out_ready;
    // A pop frees a slot on the same edge, so a full queue still accepts a fetch.
    assign push = !redirect_valid && (!full || pop);
    always_comb begin
        fetch_pc_d = redirect_valid ? {redirect_address[XLEN-1:2], 2'b00}
                   : push           ? fetch_pc_q + XLEN'(INSTR_BYTES)
                   :                  fetch_pc_q;
    end
    always_ff @(posedge clk) begin
        fetch_pc_q <= reset ? {initial_address[XLEN-1:2], 2'b00} : fetch_pc_d;
    end
    assign wr_entry = '{pc: fetch_pc_q, instruction: mem_instruction};
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );
    assign mem_address     = fetch_pc_q;
    assign out_valid       = count != '0;
    assign out_pc          = empty ? '0 : head.pc;
    assign out_instruction = empty ? XLEN'(NOP_INSTR) : head.instruction;
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb_instruction_fetch_buffer: directed and random checks of the fetch buffer against a queue model
module tb_instruction_fetch_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic reset, redirect_valid, out_ready, out_valid;
    logic [31:0] initial_address, redirect_address, mem_address, mem_instruction, out_pc, out_instruction;
    int errors = 0, checks = 0;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t q[$];
    logic [31:0] m_pc;
    always #5 clk = ~clk;
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction
    assign mem_instruction = memf(mem_address);
    instruction_fetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .initial_address  (initial_address),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .mem_address      (mem_address),
        .mem_instruction  (mem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        logic r, rv, rd;
        logic [31:0] ra, ia;
        ent_t e;
        r = reset; rv = redirect_valid; rd = out_ready; ra = redirect_address; ia = initial_address;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_pc = {ia[31:2], 2'b00};
        end else if (rv) begin
            q.delete();
            m_pc = {ra[31:2], 2'b00};
        end else begin
            if (rd && q.size() != 0) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                e.pc = m_pc; e.ins = memf(m_pc);
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        chk("mem_address", mem_address, m_pc);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_pc", out_pc, q.size() != 0 ? q[0].pc : 32'h0);
        chk("out_instruction", out_instruction, q.size() != 0 ? q[0].ins : NOP);
    endtask
    task automatic do_reset(input logic [31:0] ia, input logic rdy);
        reset = 1'b1; initial_address = ia; out_ready = rdy; redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask
    initial begin
        reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        initial_address = 32'h100; redirect_address = 32'h0;
        @(negedge clk);
        do_reset(32'h100, 1'b1);
        chk("rst_mem_address", mem_address, 32'h100);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", out_instruction, NOP);
        step(); chk("seq_pc0", out_pc, 32'h100);
        step(); chk("seq_pc1", out_pc, 32'h104);
        step(); chk("seq_pc2", out_pc, 32'h108);
        chk("seq_ins2", out_instruction, memf(32'h108));
        do_reset(32'h100, 1'b0);
        repeat (4) step();
        chk("full_mem_address", mem_address, 32'h110);
        chk("full_head", out_pc, 32'h100);
        step();
        chk("full_hold", mem_address, 32'h110);
        out_ready = 1'b1;
        step();
        chk("full_pushpop_head", out_pc, 32'h104);
        chk("full_pushpop_addr", mem_address, 32'h114);
        do_reset(32'h100, 1'b0);
        repeat (3) step();
        redirect_valid = 1'b1; redirect_address = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(out_valid), 32'h0);
        chk("redir_mem_address", mem_address, 32'h200);
        step();
        chk("redir_target_pc", out_pc, 32'h200);
        out_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_address = 32'h400; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("redir_pop_empty", 32'(out_valid), 32'h0);
        step();
        chk("redir_pop_head", out_pc, 32'h400);
        do_reset(32'hFFFF_FFF8, 1'b1);
        step(); chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        step(); chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        step(); chk("wrap_pc2", out_pc, 32'h0000_0000);
        reset = 1'b1; redirect_valid = 1'b1; redirect_address = 32'h5000; initial_address = 32'h101;
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        chk("rst_redir_addr", mem_address, 32'h100);
        chk("rst_redir_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            redirect_valid = $urandom_range(0, 11) == 0;
            redirect_address = $urandom();
            reset = $urandom_range(0, 63) == 0;
            initial_address = $urandom();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Fetch stage that owns the fetch PC, drives the instruction memory read address, and queues fetched {pc, instruction} pairs in a small FIFO for the decode stage. It sits between the combinational instruction memory and decode, and replaces the bare PC + 4 loop with a valid/ready decoupled fetch. A redirect input (branch/jump/trap target) flushes queued work and restarts fetch at a new address.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16
- XLEN, 32: address and instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- initial_address  in  XLEN  fetch PC loaded on reset
- redirect_valid  in  1  flush request, sampled at clk edge
- redirect_address  in  XLEN  new fetch PC when redirect_valid
- mem_address  out  XLEN  read address to instruction memory; equals fetch_pc
- mem_instruction  in  XLEN  combinational read data for mem_address, same cycle
- out_valid  out  1  head entry present
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  XLEN  PC of head entry
- out_instruction  out  XLEN  instruction of head entry; NOP (0x00000013) when empty

## Operation
- State: fetch_pc register, DEPTH-entry storage of {pc, instruction}, read pointer, write pointer, count (width clog2(DEPTH)+1).
- pop = out_valid && out_ready.
- push = !redirect_valid && (count < DEPTH || pop). Push writes {fetch_pc, mem_instruction} at write pointer; fetch_pc <= fetch_pc + 4.
- fetch_pc + 4 is modulo 2^XLEN: 0xFFFFFFFC advances to 0x00000000.
- When full with no pop, no push; fetch_pc holds and mem_address is stable.
- Simultaneous push and pop while full: both occur; count unchanged.
- Pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1 at an edge): count <= 0, pointers <= 0, fetch_pc <= {redirect_address[XLEN-1:2], 2'b00}; no push that cycle. A pop presented in the redirect cycle is still a completed handshake from decode's view. Redirect has priority over push.
- Reset has priority over redirect and all other activity.
- out_valid = (count != 0). out_pc/out_instruction are read combinationally from the head entry. When empty they are 0 and NOP respectively.

## Timing
- Reset values after an edge with reset=1: fetch_pc = initial_address with bits [1:0] cleared, count 0, out_valid 0, out_pc 0, out_instruction 0x00000013, mem_address = aligned initial_address.
- Reset mid-operation discards all entries on that edge. The first push happens on the first edge with reset=0.
- Fetch-to-output latency is 1 cycle: an instruction present on mem_instruction at edge N is visible at the head by N+1 if the FIFO was empty.
- Redirect-to-output latency is 2 edges: the flush edge, then the push of the target instruction. out_valid is 0 for exactly one cycle after a redirect.
- Steady state with out_ready held at 1 gives one instruction per cycle, with out_pc incrementing by 4.
- out_ready may toggle freely. Head data is stable while out_valid=1 and out_ready=0 (no redirect).

## Structure
- Shared package (fetch_pkg): XLEN default, INSTR_BYTES = 4, NOP_INSTR = 32'h00000013, and a packed struct fetch_entry_t {pc, instruction}.
- Sub-module fetch_fifo: parameterised DEPTH, carrying fetch_entry_t, with synchronous reset and flush inputs, push/pop, and count/full/empty outputs. fetch_pc and the push/redirect control live in instruction_fetch_buffer.
- The instruction memory stays external. mem_address must be driven directly from the fetch_pc register, with no combinational path from inputs.

## Test plan
- Reset with initial_address=0x00000100, out_ready=1 → mem_address 0x100, out_valid 0. Next cycles out_pc 0x100, 0x104, 0x108, one per cycle, with matching memory words.
- out_ready=0 from reset, DEPTH=4 → after 4 edges count=4; mem_address holds 0x110; head stays pc 0x100. Raising out_ready with full FIFO → push and pop same edge, count stays 4.
- Redirect to 0x00000203 while 3 entries are queued → next cycle out_valid 0 and mem_address 0x200. The cycle after, out_pc 0x200.
- Redirect and out_ready=1 in the same cycle as a pending head → head consumed once, and the FIFO is empty afterwards (no stale entries).
- initial_address=0xFFFFFFF8, out_ready=1 → out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert reset for one cycle mid-stream with redirect_valid=1 simultaneously → state equals the reset values; redirect_address is ignored.
